// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction memory port, decode handshake and redirect input.
// master is the fetch unit; slave is the memory/decode/datapath side.
interface fetch_unit_if #(
    parameter int n = 32
);
    logic         imem_req_valid;
    logic         imem_req_ready;
    logic [n-1:0] imem_addr;
    logic         imem_rsp_valid;
    logic [n-1:0] imem_rsp_data;
    logic         redirect_valid;
    logic [n-1:0] redirect_pc;
    logic         instr_valid;
    logic         instr_ready;
    logic [n-1:0] instr;
    logic [5:0]   op;
    logic [n-1:0] pc;
    logic [n-1:0] pc_plus4;
    logic [n-1:0] fetch_count;

    modport master (
        output imem_req_valid, imem_addr, instr_valid, instr, op, pc, pc_plus4, fetch_count,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc,
               instr_ready
    );

    modport slave (
        input  imem_req_valid, imem_addr, instr_valid, instr, op, pc, pc_plus4, fetch_count,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc,
               instr_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, issues one word fetch at a time and offers the
// returned word to decode; redirects override sequential fetch and squash stale words.
module fetch_unit #(
    parameter int           n        = 32,
    parameter logic [n-1:0] RESET_PC = '0
) (
    input logic          clk,
    input logic          rst_n,
    fetch_unit_if.master bus
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

    state_t       state;
    logic [n-1:0] pc_r;
    logic [n-1:0] instr_r;
    logic [n-1:0] count;
    logic         drop;
    logic [n-1:0] target;
    logic         req_fire;

    assign target   = bus.redirect_pc & ~n'(3);
    assign req_fire = (state == REQ) && bus.imem_req_ready;

    assign bus.imem_req_valid = (state == REQ);
    assign bus.imem_addr      = pc_r;
    // Only combinational path: a redirect in HOLD must block the handshake in the same cycle.
    assign bus.instr_valid    = (state == HOLD) && !bus.redirect_valid;
    assign bus.instr          = instr_r;
    assign bus.op             = instr_r[31:26];
    assign bus.pc             = pc_r;
    assign bus.pc_plus4       = pc_r + n'(4);
    assign bus.fetch_count    = count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            pc_r    <= RESET_PC;
            instr_r <= '0;
            count   <= '0;
            drop    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.redirect_valid) pc_r <= target;
                    state <= REQ;
                end
                REQ: begin
                    if (bus.redirect_valid) pc_r <= target;
                    if (req_fire) begin
                        state <= WAIT;
                        // The word now in flight belongs to the old path.
                        if (bus.redirect_valid) drop <= 1'b1;
                    end
                end
                WAIT: begin
                    if (bus.redirect_valid) begin
                        pc_r <= target;
                        if (bus.imem_rsp_valid) begin
                            drop  <= 1'b0;
                            state <= REQ;
                        end else begin
                            drop <= 1'b1;
                        end
                    end else if (bus.imem_rsp_valid) begin
                        if (drop) begin
                            drop  <= 1'b0;
                            state <= REQ;
                        end else begin
                            instr_r <= bus.imem_rsp_data;
                            state   <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (bus.redirect_valid) begin
                        pc_r  <= target;
                        state <= REQ;
                    end else if (bus.instr_ready) begin
                        pc_r  <= pc_r + n'(4);
                        count <= count + n'(1);
                        state <= REQ;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
